instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction memory read interface.
- Holds the PC, issues word-aligned read requests with a 1-cycle synchronous read latency, and captures the returned words into a small flushable buffer.
- Presents instruction/PC pairs to decode over a valid/ready handshake.
- Handles control-flow redirects and misaligned redirect targets. Sits between the branch/execute stage and the instruction memory.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/fetch_buffer.sv | 61 ++++++
 rtl/instruction_fetch_unit.sv | 97 +++++++++
 tb/tb_instruction_fetch_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset/NOP constants and the buffer entry type for the fetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;

  localparam logic [ADDR_WIDTH-1:0]  RESET_PC        = 32'h0100_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 32'h1111_1111;
  localparam logic [ADDR_WIDTH-1:0]  WORD_ALIGN_MASK = 32'h0000_0003;

  // One decode-side buffer slot: instruction word plus the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  pc;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return (addr & WORD_ALIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, decode and redirect signals of the fetch unit; master = fetch unit side.
interface instruction_fetch_unit_if;
  import fetch_pkg::*;

  logic                   imem_readEnable;
  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_instruction;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [INSTR_WIDTH-1:0] dec_instruction;
  logic [ADDR_WIDTH-1:0]  dec_pc;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   fetch_fault;
  logic [ADDR_WIDTH-1:0]  fault_pc;

  modport master (
    output imem_readEnable, imem_address, dec_valid, dec_instruction, dec_pc,
           fetch_fault, fault_pc,
    input  imem_instruction, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_readEnable, imem_address, dec_valid, dec_instruction, dec_pc,
           fetch_fault, fault_pc,
    output imem_instruction, dec_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {instr, pc} entries with flush; head is read combinationally.
module fetch_buffer import fetch_pkg::*; #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  fetch_entry_t    push_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_en, pop_en;

  // Guard against popping empty or pushing into a full buffer without a pop.
  assign pop_en  = pop_i && (count_q != '0);
  assign push_en = push_i && ((count_q != CntW'(Depth)) || pop_en);

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push_en) - CntW'(pop_en);
    if (push_en) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC, request issue, in-flight tracking and fault control in front of the decode buffer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC        = fetch_pkg::RESET_PC,
  parameter int unsigned BUF_DEPTH       = 2,
  parameter logic [31:0] NOP_INSTRUCTION = fetch_pkg::NOP_INSTRUCTION
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);
  import fetch_pkg::fetch_entry_t;
  import fetch_pkg::is_misaligned;
  import fetch_pkg::INSTR_WIDTH;

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  // NOP words are data like any other; only the width has to agree with the datapath.
  if (BUF_DEPTH < 2 || $bits(NOP_INSTRUCTION) != INSTR_WIDTH) begin : g_param_check
    $error("instruction_fetch_unit: BUF_DEPTH must be >= 2 and NOP width must match");
  end

  logic [31:0]     pc_q, pc_d, inflight_pc_q, inflight_pc_d, fault_pc_q, fault_pc_d;
  logic            inflight_q, inflight_d, fault_q, fault_d;
  logic [CntW-1:0] count;
  logic [31:0]     occupancy;
  logic            dec_valid, pop, issue, push;
  fetch_entry_t    head, push_data;

  assign dec_valid = (count != '0);
  assign pop       = dec_valid & bus.dec_ready;
  // Entries held plus the one returning this cycle, less the one leaving now.
  assign occupancy = 32'(count) + 32'(inflight_q) - 32'(pop);
  assign issue     = !reset && !bus.redirect_valid && !fault_q && (occupancy < BUF_DEPTH);
  // Returning data is only meaningful while a request is outstanding.
  assign push      = inflight_q && !bus.redirect_valid;
  assign push_data = '{instr: bus.imem_instruction, pc: inflight_pc_q};

  // Next PC, in-flight and fault state; a redirect overrides sequential fetch.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      if (is_misaligned(bus.redirect_pc)) begin
        fault_d    = 1'b1;
        fault_pc_d = bus.redirect_pc;
      end else begin
        fault_d = 1'b0;
      end
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Control registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  fetch_buffer #(
    .Depth (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (bus.redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_readEnable = issue;
  assign bus.imem_address    = pc_q;
  assign bus.dec_valid       = dec_valid;
  // Zero the head while empty so stale storage never leaks onto decode.
  assign bus.dec_instruction = dec_valid ? head.instr : '0;
  assign bus.dec_pc          = dec_valid ? head.pc : '0;
  assign bus.fetch_fault     = fault_q;
  assign bus.fault_pc        = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit with a stream-level reference model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned Depth    = 2;
  localparam logic [31:0] MemBase  = 32'h0100_0000;
  localparam logic [31:0] MemBytes = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset;
  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC        (RESET_PC),
    .BUF_DEPTH       (Depth),
    .NOP_INSTRUCTION (NOP_INSTRUCTION)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [9:0] idx;
    if (a >= MemBase && a < MemBase + MemBytes) begin
      idx = 10'((a - MemBase) >> 2);
      return mem[idx];
    end
    return NOP_INSTRUCTION;
  endfunction

  // Instruction memory: one-cycle registered read, NOP when not enabled.
  always @(posedge clk)
    bus.imem_instruction <= bus.imem_readEnable ? mem_word(bus.imem_address) : NOP_INSTRUCTION;

  int errors = 0;
  int checks = 0;

  // Reference model: which PC decode must see next, which address must be requested
  // next, words requested but not yet accepted, cycles since the last flush, fault.
  logic [31:0] m_next_pc, m_issue_pc, m_fault_pc;
  logic        m_fault;
  int          m_age, m_outst;

  logic        last_pop, last_valid, last_re;
  logic [31:0] last_pop_pc, last_pop_instr, last_fault_pc;

  task automatic model_init();
    m_next_pc  = RESET_PC;
    m_issue_pc = RESET_PC;
    m_fault    = 1'b0;
    m_fault_pc = '0;
    m_age      = 1;  // leaving reset behaves like a flush one cycle earlier
    m_outst    = 0;
  endtask

  // Drive one cycle, score every observable against the model, advance the model.
  task automatic drive_and_score(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic pop, exp_re, exp_valid;
    bus.dec_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge clk);
    pop    = bus.dec_valid & rdy;
    exp_re = !rv && !m_fault && ((m_outst - int'(pop)) < int'(Depth));
    checks++;
    if (bus.imem_readEnable !== exp_re) begin
      errors++;
      $display("FAIL readEnable t=%0t: got %b expected %b", $time, bus.imem_readEnable, exp_re);
    end
    if (exp_re) begin
      checks++;
      if (bus.imem_address !== m_issue_pc) begin
        errors++;
        $display("FAIL address t=%0t: got %h expected %h", $time, bus.imem_address, m_issue_pc);
      end
    end
    if (m_age >= 1) begin
      exp_valid = !m_fault && (m_age >= 3);
      checks++;
      if (bus.dec_valid !== exp_valid) begin
        errors++;
        $display("FAIL dec_valid t=%0t: got %b expected %b", $time, bus.dec_valid, exp_valid);
      end
    end
    if (pop) begin
      checks++;
      if (bus.dec_pc !== m_next_pc) begin
        errors++;
        $display("FAIL dec_pc t=%0t: got %h expected %h", $time, bus.dec_pc, m_next_pc);
      end
      checks++;
      if (bus.dec_instruction !== mem_word(m_next_pc)) begin
        errors++;
        $display("FAIL dec_instruction t=%0t: got %h expected %h", $time,
                 bus.dec_instruction, mem_word(m_next_pc));
      end
    end
    checks++;
    if (bus.fetch_fault !== m_fault) begin
      errors++;
      $display("FAIL fetch_fault t=%0t: got %b expected %b", $time, bus.fetch_fault, m_fault);
    end
    if (m_fault) begin
      checks++;
      if (bus.fault_pc !== m_fault_pc) begin
        errors++;
        $display("FAIL fault_pc t=%0t: got %h expected %h", $time, bus.fault_pc, m_fault_pc);
      end
    end
    last_pop       = pop;
    last_valid     = bus.dec_valid;
    last_re        = bus.imem_readEnable;
    last_pop_pc    = bus.dec_pc;
    last_pop_instr = bus.dec_instruction;
    last_fault_pc  = bus.fault_pc;
    if (pop) m_next_pc += 32'd4;
    if (rv) begin
      m_age   = 0;
      m_outst = 0;
      if (rpc[1:0] != 2'b00) begin
        m_fault    = 1'b1;
        m_fault_pc = rpc;
      end else begin
        m_fault    = 1'b0;
        m_next_pc  = rpc;
        m_issue_pc = rpc;
      end
    end else begin
      m_outst = m_outst - int'(pop) + int'(exp_re);
      if (exp_re) m_issue_pc += 32'd4;
    end
    if (m_age < 1000) m_age++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_release();
    reset              = 1'b0;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_init();
  endtask

  // Runs n cycles with ready high; reports index and PC/word of the first pop.
  task automatic run_ready(input int n, output int first_idx, output logic [31:0] first_pc,
                           output int pops);
    first_idx = -1;
    first_pc  = '0;
    pops      = 0;
    for (int i = 0; i < n; i++) begin
      drive_and_score(1'b1, 1'b0, '0);
      if (last_pop) begin
        pops++;
        if (first_idx < 0) begin
          first_idx = i;
          first_pc  = last_pop_pc;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    bus.dec_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.dec_valid !== 1'b0) begin
      errors++; $display("FAIL reset dec_valid: got %b expected 0", bus.dec_valid);
    end
    if (bus.imem_readEnable !== 1'b0) begin
      errors++; $display("FAIL reset readEnable: got %b expected 0", bus.imem_readEnable);
    end
    if (bus.fault_pc !== 32'h0) begin
      errors++; $display("FAIL reset fault_pc: got %h expected 0", bus.fault_pc);
    end
    if (bus.dec_instruction !== 32'h0) begin
      errors++; $display("FAIL reset dec_instruction: got %h expected 0", bus.dec_instruction);
    end
    if (bus.dec_pc !== 32'h0) begin
      errors++; $display("FAIL reset dec_pc: got %h expected 0", bus.dec_pc);
    end
    if (bus.fetch_fault !== 1'b0) begin
      errors++; $display("FAIL reset fetch_fault: got %b expected 0", bus.fetch_fault);
    end
    @(posedge clk);
    #1;
    do_release();
  endtask

  task automatic test_stream();
    int first_valid, pops;
    first_valid = -1;
    pops        = 0;
    for (int i = 0; i < 12; i++) begin
      drive_and_score(1'b1, 1'b0, '0);
      if (last_valid && first_valid < 0) first_valid = i;
      if (last_pop) begin
        pops++;
        if (i == 2) begin
          checks++;
          if (last_pop_instr !== 32'h0000_00A0 || last_pop_pc !== 32'h0100_0000) begin
            errors++;
            $display("FAIL stream first pair: got %h/%h expected 01000000/000000a0",
                     last_pop_pc, last_pop_instr);
          end
        end
      end
    end
    checks++;
    if (first_valid !== 2) begin
      errors++; $display("FAIL stream first valid cycle: got %0d expected 2", first_valid);
    end
    checks++;
    if (pops !== 10) begin
      errors++; $display("FAIL stream throughput: got %0d pops expected 10", pops);
    end
  endtask

  task automatic test_stall();
    int re_high, idx, pops;
    logic [31:0] fpc;
    re_high = 0;
    for (int i = 0; i < 5; i++) begin
      drive_and_score(1'b0, 1'b0, '0);
      if (last_re) re_high++;
    end
    checks++;
    if (re_high !== 0) begin
      errors++; $display("FAIL stall readEnable: got %0d high cycles expected 0", re_high);
    end
    run_ready(8, idx, fpc, pops);
    checks++;
    if (pops !== 8 || idx !== 0) begin
      errors++; $display("FAIL stall resume: got %0d pops first %0d expected 8 first 0", pops, idx);
    end
  endtask

  task automatic test_redirect_full();
    int idx, pops;
    logic [31:0] fpc;
    drive_and_score(1'b0, 1'b1, 32'h0100_0100);
    run_ready(8, idx, fpc, pops);
    checks++;
    if (idx !== 2 || fpc !== 32'h0100_0100) begin
      errors++;
      $display("FAIL redirect first: got idx %0d pc %h expected idx 2 pc 01000100", idx, fpc);
    end
  endtask

  task automatic test_fault();
    int re_high, idx, pops;
    logic [31:0] fpc;
    drive_and_score(1'b1, 1'b1, 32'h0100_0102);
    re_high = 0;
    for (int i = 0; i < 4; i++) begin
      drive_and_score(1'b1, 1'b0, '0);
      if (last_re) re_high++;
    end
    checks++;
    if (re_high !== 0 || last_fault_pc !== 32'h0100_0102) begin
      errors++;
      $display("FAIL fault hold: got re %0d fault_pc %h expected 0 and 01000102",
               re_high, last_fault_pc);
    end
    drive_and_score(1'b1, 1'b1, 32'h0100_0010);
    run_ready(6, idx, fpc, pops);
    checks++;
    if (idx !== 2 || fpc !== 32'h0100_0010) begin
      errors++;
      $display("FAIL fault clear: got idx %0d pc %h expected idx 2 pc 01000010", idx, fpc);
    end
  endtask

  task automatic test_boundary();
    int seen;
    seen = 0;
    drive_and_score(1'b1, 1'b1, 32'h0100_0FFC);
    for (int i = 0; i < 6; i++) begin
      drive_and_score(1'b1, 1'b0, '0);
      if (last_pop && last_pop_pc == 32'h0100_0FFC) begin
        seen++;
        checks++;
        if (last_pop_instr !== mem[1023]) begin
          errors++;
          $display("FAIL last word: got %h expected %h", last_pop_instr, mem[1023]);
        end
      end
      if (last_pop && last_pop_pc == 32'h0100_1000) begin
        seen++;
        checks++;
        if (last_pop_instr !== 32'h1111_1111) begin
          errors++; $display("FAIL out of range: got %h expected 11111111", last_pop_instr);
        end
      end
    end
    checks++;
    if (seen !== 2) begin
      errors++; $display("FAIL boundary pcs: got %0d seen expected 2", seen);
    end
  endtask

  task automatic test_back_to_back();
    int idx, pops;
    logic [31:0] fpc;
    drive_and_score(1'b1, 1'b1, 32'h0100_0200);
    drive_and_score(1'b1, 1'b1, 32'h0100_0300);
    drive_and_score(1'b1, 1'b1, 32'h0100_0400);
    run_ready(6, idx, fpc, pops);
    checks++;
    if (idx !== 2 || fpc !== 32'h0100_0400) begin
      errors++;
      $display("FAIL back_to_back: got idx %0d pc %h expected idx 2 pc 01000400", idx, fpc);
    end
  endtask

  task automatic test_random();
    logic        rdy, rv;
    logic [31:0] tgt;
    int          r;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      r   = int'($urandom_range(0, 99));
      rv  = (r < 6);
      tgt = MemBase + {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if (r == 0) tgt = MemBase + MemBytes - 32'd8;
      if (r == 1) tgt = tgt | 32'd2;
      drive_and_score(rdy, rv, tgt);
    end
  endtask

  task automatic test_async_reset();
    int idx, pops;
    logic [31:0] fpc;
    drive_and_score(1'b1, 1'b1, 32'h0100_0040);
    run_ready(5, idx, fpc, pops);
    bus.dec_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.imem_readEnable !== 1'b0 || bus.dec_pc !== 32'h0) begin
      errors++;
      $display("FAIL async reset: got valid %b re %b pc %h expected 0 0 0",
               bus.dec_valid, bus.imem_readEnable, bus.dec_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    do_release();
    run_ready(6, idx, fpc, pops);
    checks++;
    if (idx !== 2 || fpc !== RESET_PC) begin
      errors++;
      $display("FAIL restart: got idx %0d pc %h expected idx 2 pc %h", idx, fpc, RESET_PC);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (i < 8) ? 32'h0000_00A0 + 32'(i) : $urandom;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_fault();
    test_boundary();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
